// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle.
// The master side drives the raw pin and consumes the conditioned outputs.
// The slave side is the conditioner itself.
interface button_conditioner_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer followed by a four-state
// debounce FSM. It produces a debounced level plus one-cycle press and
// release strobes.
// Optional auto-repeat of press_pulse while the button is held is enabled by
// defining BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner #(
    parameter int unsigned CLK_FREQ    = 6000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned HOLD_MS     = 500,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   btn
);

    localparam int unsigned DB_RAW    = CLK_FREQ * DEBOUNCE_MS / 1000;
    localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned HOLD_RAW    = CLK_FREQ * HOLD_MS / 1000;
    localparam int unsigned HOLD_CYCLES = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam int unsigned RPT_RAW     = CLK_FREQ * REPEAT_MS / 1000;
    localparam int unsigned RPT_CYCLES  = (RPT_RAW < 1) ? 1 : RPT_RAW;
    localparam int unsigned MAX_HR      = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
    localparam int unsigned CNT_MAX     = (MAX_HR > DB_CYCLES) ? MAX_HR : DB_CYCLES;
`else
    localparam int unsigned CNT_MAX     = DB_CYCLES;
`endif

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RPT_LIMIT  = CNT_W'(RPT_CYCLES);
`endif

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    logic             sync1;
    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rpt_cnt;
    logic [CNT_W-1:0] rpt_next;
    logic             hold_done;
`endif

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn.btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    // Next value of the repeat counter while the button is held.
    always_comb begin
        rpt_next = rpt_cnt + CNT_ONE;
    end
`endif

    // Debounce FSM with registered level and strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            hold_done <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sync2) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                    end
                end

                CHK_HI: begin
                    if (!sync2) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == DB_LIMIT) begin
                        state   <= STABLE_HI;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                        rpt_cnt   <= '0;
                        hold_done <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STABLE_HI: begin
                    if (!sync2) begin
                        // Leaving for CHK_LO freezes the repeat counter.
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                    end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                    else if (!hold_done && rpt_next == HOLD_LIMIT) begin
                        press_q   <= 1'b1;
                        rpt_cnt   <= '0;
                        hold_done <= 1'b1;
                    end else if (hold_done && rpt_next == RPT_LIMIT) begin
                        press_q <= 1'b1;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_next;
                    end
`endif
                end

                CHK_LO: begin
                    if (sync2) begin
                        // Low glitch rejected; repeat timing resumes where it stopped.
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == DB_LIMIT) begin
                        state     <= STABLE_LO;
                        cnt       <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                        rpt_cnt   <= '0;
                        hold_done <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with DB=5, HOLD=20, RPT=10 cycles.
// Expectations switch on BUTTON_CONDITIONER_AUTO_REPEAT_EN for the long hold.
module tb_button_conditioner;

    logic clk;
    logic reset;

    button_conditioner_if bif ();

    button_conditioner #(
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (5),
        .HOLD_MS     (20),
        .REPEAT_MS   (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   press_q[$];
    int   rel_q[$];
    logic lvl_at[0:63];
    logic overlap = 1'b0;
    int   acc;
    int   exp_rpt[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, logging strobe edges (1-based) and the level after each edge.
    task automatic run(input int n);
        press_q.delete();
        rel_q.delete();
        for (int i = 1; i <= n; i++) begin
            step();
            lvl_at[i] = bif.btn_level;
            if (bif.press_pulse === 1'b1)   press_q.push_back(i);
            if (bif.release_pulse === 1'b1) rel_q.push_back(i);
            if (bif.press_pulse === 1'b1 && bif.release_pulse === 1'b1) overlap = 1'b1;
        end
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.btn_raw = 1'b0;
        reset = 1'b1;
        step();
        step();
        check("rst_level", bif.btn_level, 0);
        check("rst_press", bif.press_pulse, 0);
        check("rst_release", bif.release_pulse, 0);

        // Clean press
        reset = 1'b0;
        bif.btn_raw = 1'b1;
        run(12);
        check("s1_press_n", press_q.size(), 1);
        check("s1_press_at", first_of(press_q), 8);
        check("s1_rel_n", rel_q.size(), 0);
        check("s1_lvl_e7", lvl_at[7], 0);
        check("s1_lvl_e8", lvl_at[8], 1);

        // Clean release
        bif.btn_raw = 1'b0;
        run(10);
        check("rel_n", rel_q.size(), 1);
        check("rel_at", first_of(rel_q), 8);
        check("rel_press_n", press_q.size(), 0);
        check("rel_lvl_e7", lvl_at[7], 1);
        check("rel_lvl_e8", lvl_at[8], 0);

        // Bounce train: 1,1,0,0 five times, then steady high
        acc = 0;
        for (int p = 0; p < 5; p++) begin
            bif.btn_raw = 1'b1;
            run(2);
            acc += press_q.size() + rel_q.size() + int'(lvl_at[1]) + int'(lvl_at[2]);
            bif.btn_raw = 1'b0;
            run(2);
            acc += press_q.size() + rel_q.size() + int'(lvl_at[1]) + int'(lvl_at[2]);
        end
        check("bounce_quiet", acc, 0);
        bif.btn_raw = 1'b1;
        run(12);
        check("bounce_press_n", press_q.size(), 1);
        check("bounce_press_at", first_of(press_q), 8);
        check("bounce_lvl_e7", lvl_at[7], 0);

        // 4-cycle low glitch while held: no release
        bif.btn_raw = 1'b0;
        run(4);
        acc = rel_q.size() + press_q.size();
        bif.btn_raw = 1'b1;
        run(12);
        acc += rel_q.size() + press_q.size();
        check("glitch_no_strobe", acc, 0);
        check("glitch_lvl", lvl_at[12], 1);
        check("glitch_lvl_mid", lvl_at[4], 1);

        // Second clean release
        bif.btn_raw = 1'b0;
        run(10);
        check("rel2_at", first_of(rel_q), 8);

        // Reset mid-qualification
        bif.btn_raw = 1'b1;
        run(4);
        check("mid_no_press", press_q.size(), 0);
        reset = 1'b1;
        step();
        check("mid_rst_level", bif.btn_level, 0);
        check("mid_rst_press", bif.press_pulse, 0);
        check("mid_rst_release", bif.release_pulse, 0);
        reset = 1'b0;
        run(12);
        check("mid_press_n", press_q.size(), 1);
        check("mid_press_at", first_of(press_q), 8);

        // Reset while stable high, button still held
        reset = 1'b1;
        step();
        check("hi_rst_level", bif.btn_level, 0);
        check("hi_rst_release", bif.release_pulse, 0);
        check("hi_rst_press", bif.press_pulse, 0);
        reset = 1'b0;
        run(12);
        check("hi_rel_n", rel_q.size(), 0);
        check("hi_press_n", press_q.size(), 1);
        check("hi_press_at", first_of(press_q), 8);
        check("hi_lvl_e7", lvl_at[7], 0);

        // Return low, then hold for 60 cycles
        bif.btn_raw = 1'b0;
        run(10);
        check("rel3_at", first_of(rel_q), 8);
        bif.btn_raw = 1'b1;
        run(60);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        exp_rpt = '{8, 28, 38, 48, 58};
`else
        exp_rpt = '{8};
`endif
        check("hold_press_n", press_q.size(), exp_rpt.size());
        for (int k = 0; k < exp_rpt.size() && k < press_q.size(); k++)
            check($sformatf("hold_press_%0d", k), press_q[k], exp_rpt[k]);
        check("hold_rel_n", rel_q.size(), 0);
        check("hold_lvl", lvl_at[60], 1);

        check("no_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
